out_port_allocator: RTL
=======================

# out_port_allocator

Per-output-port switch allocator and credit controller for the 5-port wormhole router. Arbitrates among the five router input buffers (N, E, S, W, local PE inject) for one output link and locks the link to the winner for the whole packet. Tracks downstream buffer credits and drives the registered flit/valid pair onto the link. Five instances per router, one per output direction including eject.

## Interface
Parameters:
- NUM_IN, 5, number of requesting input ports
- FLIT_W, 20, flit width in bits
- CREDITS, 4, downstream buffer depth in flits (initial credit count)
- CNT_W, 3, credit counter width; must hold 0..CREDITS

Ports:
- clk  input  1  sole clock, rising edge
- RST  input  1  asynchronous, active-low reset
- req  input  NUM_IN  input i has a flit at its buffer head
- flit_in  input  NUM_IN*FLIT_W  head flit of each input buffer; input i at [i*FLIT_W +: FLIT_W]
- grant  output  NUM_IN  one-hot pop strobe to input i, combinational, same cycle
- o  output  FLIT_W  registered outgoing flit
- vo  output  1  o valid, registered
- ci  input  1  one-cycle credit return pulse from downstream
- credit_cnt  output  CNT_W  current credits
- busy  output  1  high while in LOCKED

## Operation
- Flit type = flit[FLIT_W-1 -: 2]: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE (head+tail).
- State IDLE: eligible inputs = req[i] && type in {HEAD, SINGLE}. If credit_cnt>0 and any eligible, round-robin pick starting at rr_ptr; grant winner. HEAD -> LOCKED, owner = winner. SINGLE -> stay IDLE, rr_ptr = winner+1 mod NUM_IN.
- BODY/TAIL at a buffer head while IDLE: never granted, left in place.
- State LOCKED: grant[owner] only when req[owner] && credit_cnt>0; other inputs ignored regardless of type. Granted TAIL -> IDLE, rr_ptr = owner+1 mod NUM_IN. Granted HEAD/SINGLE while LOCKED is forwarded as a body flit (no state change).
- Credit counter: -1 per grant, +1 per ci; grant and ci same cycle -> unchanged. Never grants at 0. ci at CREDITS: counter holds at CREDITS.
- Output register: o <= granted flit, vo <= 1 in the cycle after grant; vo <= 0, o holds when no grant.
- At most one grant bit per cycle.

## Timing
- Reset (RST low, asynchronous): state IDLE, rr_ptr 0, owner 0, credit_cnt CREDITS, o 0, vo 0, busy 0, grant 0 (req-gated after release).
- grant-to-vo latency: 1 cycle. Back-to-back grants every cycle while credits last.
- ci at cycle t usable for a grant at t+1 (counter registered); credit_cnt=0 with ci at t: no grant at t.
- busy rises the cycle after a HEAD grant, falls the cycle after the TAIL grant.
- Arbitration for the next packet may grant in the cycle right after the TAIL grant.

## Configuration
- OUT_PORT_ALLOC_CHECK_EN defined: adds output err (1 bit, reset 0, sticky until reset), set on ci while credit_cnt==CREDITS, or on grant[owner] of a HEAD/SINGLE flit while LOCKED.
- Undefined: no err port, no checking logic; behaviour otherwise identical.

## Structure
- Shared package noc_pkg: FLIT_W, flit-type encodings (HEAD/BODY/TAIL/SINGLE), type field position, allocator state enum (IDLE, LOCKED).
- One sub-module rr_arbiter: NUM_IN-wide combinational round-robin picker (req mask, pointer in, one-hot grant + index out); pointer register stays in out_port_allocator.

## Test plan
- Single SINGLE flit on input 2, credits 4 -> grant=5'b00100 same cycle, vo=1 with o=flit next cycle, credit_cnt=3, rr_ptr=3.
- Inputs 0 and 3 request HEAD simultaneously, rr_ptr 0 -> input 0 wins; 3-flit packet (HEAD, BODY, TAIL) fully forwarded before input 3 granted; input 3 granted the cycle after input 0's TAIL.
- Credits 4, no ci, 6-flit packet -> 4 grants, then grant 0 with busy=1; one ci pulse -> exactly one further grant.
- Grant and ci in same cycle at credit_cnt 2 -> credit_cnt stays 2.
- BODY flit at head of input 1 while IDLE -> no grant, vo stays 0.
- RST low mid-packet (LOCKED, credit_cnt 1) -> immediately vo 0, busy 0, credit_cnt 4; after release a HEAD on input 4 is granted normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared router definitions: flit width, flit-type encodings and the
// output-port allocator state type.
package noc_pkg;

  localparam int FLIT_W = 20;
  localparam int TYPE_W = 2;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

  function automatic logic is_head_like(input flit_type_e t);
    return (t == FT_HEAD) || (t == FT_SINGLE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans the request mask starting at ptr_i
// and returns the first requester as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int unsigned N     = 5,
  parameter int unsigned PTR_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  int unsigned j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/out_port_allocator.sv
// Per-output-port switch allocator and credit controller for the wormhole router.
// Optional sticky protocol error output enabled by OUT_PORT_ALLOC_CHECK_EN.
module out_port_allocator
  import noc_pkg::*;
#(
  parameter int NUM_IN  = 5,
  parameter int FLIT_W  = noc_pkg::FLIT_W,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic [NUM_IN-1:0]        req,
  input  logic [NUM_IN*FLIT_W-1:0] flit_in,
  output logic [NUM_IN-1:0]        grant,
  output logic [FLIT_W-1:0]        o,
  output logic                     vo,
  input  logic                     ci,
  output logic [CNT_W-1:0]         credit_cnt,
  output logic                     busy
`ifdef OUT_PORT_ALLOC_CHECK_EN
  ,
  output logic                     err
`endif
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  alloc_state_e     state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] credit_q, credit_d;
  logic [FLIT_W-1:0] o_q, o_d;
  logic             vo_q, vo_d;

  logic [FLIT_W-1:0] flit_arr [NUM_IN];
  flit_type_e        ft_arr   [NUM_IN];
  logic [NUM_IN-1:0] eligible;
  logic [NUM_IN-1:0] arb_gnt;
  logic [PTR_W-1:0]  arb_idx;
  logic              arb_any;

  logic [NUM_IN-1:0] grant_d;
  logic [PTR_W-1:0]  sel;
  logic              any_grant;
  logic              has_credit;
  flit_type_e        sel_type;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (32'(p) >= NUM_IN - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      flit_arr[i] = flit_in[i*FLIT_W +: FLIT_W];
      ft_arr[i]   = flit_type_e'(flit_arr[i][FLIT_W-1 -: TYPE_W]);
      eligible[i] = req[i] && is_head_like(ft_arr[i]);
    end
  end

  rr_arbiter #(
    .N     (NUM_IN),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req_i (eligible),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign has_credit = (credit_q != '0);

  // grant is held low while RST is asserted so no input is popped during reset.
  always_comb begin
    grant_d  = '0;
    sel      = arb_idx;
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (RST && has_credit) begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_d = arb_gnt;
            sel     = arb_idx;
            if (ft_arr[arb_idx] == FT_HEAD) begin
              state_d = ST_LOCKED;
              owner_d = arb_idx;
            end else begin
              rr_ptr_d = ptr_inc(arb_idx);
            end
          end
        end
        ST_LOCKED: begin
          if (req[owner_q]) begin
            grant_d[owner_q] = 1'b1;
            sel              = owner_q;
            if (ft_arr[owner_q] == FT_TAIL) begin
              state_d  = ST_IDLE;
              rr_ptr_d = ptr_inc(owner_q);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign any_grant = |grant_d;
  assign sel_type  = ft_arr[sel];

  always_comb begin
    credit_d = credit_q;
    unique case ({any_grant, ci})
      2'b10:   credit_d = credit_q - CNT_W'(1);
      2'b01:   credit_d = (credit_q == CNT_W'(CREDITS)) ? credit_q : credit_q + CNT_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_comb begin
    o_d  = o_q;
    vo_d = 1'b0;
    if (any_grant) begin
      o_d  = flit_arr[sel];
      vo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      credit_q <= CNT_W'(CREDITS);
      o_q      <= '0;
      vo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      o_q      <= o_d;
      vo_q     <= vo_d;
    end
  end

  assign grant      = grant_d;
  assign o          = o_q;
  assign vo         = vo_q;
  assign credit_cnt = credit_q;
  assign busy       = (state_q == ST_LOCKED);

`ifdef OUT_PORT_ALLOC_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      err_q <= 1'b0;
    end else if ((ci && (credit_q == CNT_W'(CREDITS))) ||
                 ((state_q == ST_LOCKED) && any_grant && is_head_like(sel_type))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule
